mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3: SRAM access wait states, legal range 1..15.
REQ-002 Parameter SRAM_AW, default 16: SRAM word-address width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port if_req, input, 1: fetch read request, held until if_ready.
REQ-006 Port if_addr, input, 32: fetch byte address.
REQ-007 Ports if_rdata (output, 32, fetch read data) and if_ready (output, 1, one-cycle completion pulse) SHALL exist.
REQ-008 Ports mem_r_en and mem_w_en (inputs, 1 each) SHALL carry the data-port read/write request, held until mem_ready.
REQ-009 Ports mem_addr (input, 32, data byte address) and mem_wdata (input, 32, store data) SHALL exist.
REQ-010 Ports mem_rdata (output, 32, load data) and mem_ready (output, 1, one-cycle completion pulse) SHALL exist.
REQ-011 Ports if_stall and mem_stall (outputs, 1 each) SHALL be the per-port pipeline freeze signals.
REQ-012 SRAM-side outputs SHALL be sram_en (1), sram_we (1), sram_addr (SRAM_AW) and sram_wdata (32); sram_rdata (input, 32) SHALL carry SRAM read data.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE, a pending data request (mem_r_en|mem_w_en) SHALL win over if_req; the winner is latched as grant_data=1 or 0.
REQ-015 On a grant, the address, write data and direction SHALL be latched into internal registers, and the FSM SHALL move IDLE->ACCESS with counter=WAIT_CYCLES-1.
REQ-016 In ACCESS, sram_en=1, sram_we=latched write, sram_addr=latched addr[SRAM_AW+1:2], sram_wdata=latched data.
REQ-017 In ACCESS, the counter SHALL decrement each cycle; at counter==0 the FSM SHALL move ACCESS->DONE and capture sram_rdata into a read register.
REQ-018 In DONE, exactly one of if_ready/mem_ready SHALL be 1 (per grant), and the FSM SHALL return DONE->IDLE unconditionally.
REQ-019 Latency from request acceptance in IDLE to the ready pulse SHALL be WAIT_CYCLES+1 cycles; back-to-back accesses SHALL spend one IDLE cycle between them.
REQ-020 if_rdata and mem_rdata SHALL both reflect the read register; their values are valid only in the ready cycle.
REQ-021 if_stall SHALL equal if_req & ~if_ready, and mem_stall SHALL equal (mem_r_en|mem_w_en) & ~mem_ready, both combinational.
REQ-022 Requesters SHALL drop or change their request in the cycle after ready; the arbiter SHALL NOT re-serve in DONE.
REQ-023 With mem_r_en and mem_w_en both 1, the access SHALL be treated as a write.
REQ-024 Request changes during ACCESS SHALL be ignored; the latched values govern the access.
REQ-025 A fetch request waiting behind a data access SHALL be granted in the next IDLE if no data request is pending.
REQ-026 Outside ACCESS, sram_en and sram_we SHALL be 0.

Reset
REQ-027 When rst=0, the state SHALL be IDLE, the counter 0, grant_data 0 and all latched registers 0, asynchronously.
REQ-028 During and after reset, all ready, sram_en and sram_we outputs SHALL be 0, and rdata outputs 0.
REQ-029 A reset during ACCESS SHALL abort the access with no ready pulse; the requester re-issues after reset.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the WAIT_CYCLES default.
REQ-031 The block SHALL be a single module with no sub-modules; the wait counter stays inline.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x10, WAIT_CYCLES=3 -> sram_addr=0x0004 for 3 cycles, then if_ready pulse with if_rdata equal to the SRAM word.
REQ-033 Collision: if_req and mem_r_en both rise in the same cycle -> data served first (mem_ready at +4), then fetch (if_ready at +9).
REQ-034 Store: mem_w_en=1, addr=0x400, wdata=0xDEADBEEF -> sram_we=1 with sram_addr=0x0100 for 3 cycles, and mem_ready pulses once.
REQ-035 Reset mid-ACCESS: rst=0 in the 2nd ACCESS cycle -> sram_en=0 immediately, no ready pulse, and FSM in IDLE after release.
REQ-036 Stall check: during a held if_req, if_stall=1 every cycle until the if_ready cycle, where if_stall=0.
REQ-037 WAIT_CYCLES=1 read -> ready arrives 2 cycles after acceptance.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data SRAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 3;
  localparam int unsigned CNT_W               = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported wait-stated SRAM.
// Data requests win over fetch; each access is IDLE -> ACCESS x WAIT_CYCLES -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned SRAM_AW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               if_stall,
  output logic               mem_stall,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [CNT_W-1:0] COUNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic               grant_data_q;
  logic               we_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               data_req;
  logic               accept;
  logic               unused_addr_bits;

  assign data_req = mem_r_en | mem_w_en;
  assign accept   = (state_q == IDLE) && (data_req || if_req);

  // Only the word-address slice reaches the SRAM; byte offset and high bits are dropped.
  assign unused_addr_bits = ^{if_addr, mem_addr};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and SRAM/handshake outputs.
  always_comb begin
    state_d    = state_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if_ready   = 1'b0;
    mem_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req || if_req) state_d = ACCESS;
      end
      ACCESS: begin
        sram_en    = 1'b1;
        sram_we    = we_q;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        if (count_q == '0) state_d = DONE;
      end
      DONE: begin
        if_ready  = ~grant_data_q;
        mem_ready = grant_data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      grant_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else if (accept) begin
      grant_data_q <= data_req;
      we_q         <= data_req & mem_w_en;
      addr_q       <= data_req ? mem_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
      wdata_q      <= mem_wdata;
      count_q      <= COUNT_INIT;
    end else if (state_q == ACCESS) begin
      if (count_q == '0) rdata_q <= sram_rdata;
      else               count_q <= count_q - 1'b1;
    end
  end

  assign if_rdata  = rdata_q;
  assign mem_rdata = rdata_q;
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = data_req & ~mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WAIT_CYCLES=3 and WAIT_CYCLES=1 instances).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  int unsigned checks;
  int unsigned failures;

  // WAIT_CYCLES=3 instance
  logic        if_req, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_r_en, mem_w_en, mem_ready, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        sram_en, sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  // WAIT_CYCLES=1 instance
  logic        w1_if_req, w1_if_ready, w1_if_stall;
  logic [31:0] w1_if_addr, w1_if_rdata;
  logic        w1_mem_r_en, w1_mem_w_en, w1_mem_ready, w1_mem_stall;
  logic [31:0] w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
  logic        w1_sram_en, w1_sram_we;
  logic [15:0] w1_sram_addr;
  logic [31:0] w1_sram_wdata, w1_sram_rdata;

  // SRAM model: word content is a fixed tag plus its word address.
  assign sram_rdata    = {16'hC0DE, sram_addr};
  assign w1_sram_rdata = {16'hC0DE, w1_sram_addr};

  mem_arbiter #(.WAIT_CYCLES(3), .SRAM_AW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .if_stall(if_stall), .mem_stall(mem_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(16)) dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ready(w1_if_ready),
    .mem_r_en(w1_mem_r_en), .mem_w_en(w1_mem_w_en), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
    .if_stall(w1_if_stall), .mem_stall(w1_mem_stall),
    .sram_en(w1_sram_en), .sram_we(w1_sram_we), .sram_addr(w1_sram_addr),
    .sram_wdata(w1_sram_wdata), .sram_rdata(w1_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req = 0; if_addr = '0; mem_r_en = 0; mem_w_en = 0; mem_addr = '0; mem_wdata = '0;
    w1_if_req = 0; w1_if_addr = '0; w1_mem_r_en = 0; w1_mem_w_en = 0;
    w1_mem_addr = '0; w1_mem_wdata = '0;
    #1;
    checks++;
    if ({if_ready, mem_ready, sram_en, sram_we} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {if_ready, mem_ready, sram_en, sram_we});
    end
    checks++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, mem_rdata);
    end
    step; step;
    checks++;
    if ({sram_en, w1_sram_en, if_ready, w1_mem_ready} !== 4'b0000) begin
      failures++; $display("FAIL reset_hold got=%b exp=0000", {sram_en, w1_sram_en, if_ready, w1_mem_ready});
    end
    rst = 1'b1;
    step;
  endtask

  task automatic test_fetch;
    if_addr = 32'h10; if_req = 1'b1;
    #1;
    checks++;
    if (if_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall0 got=%b exp=1", if_stall); end
    for (int k = 1; k <= 3; k++) begin
      step;
      checks++;
      if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 16'h0004}) begin
        failures++; $display("FAIL fetch_access cyc=%0d got=%b%b_%h exp=10_0004", k, sram_en, sram_we, sram_addr);
      end
      checks++;
      if (if_ready !== 1'b0 || if_stall !== 1'b1) begin
        failures++; $display("FAIL fetch_wait cyc=%0d got=rdy%b stall%b exp=rdy0 stall1", k, if_ready, if_stall);
      end
    end
    step;
    checks++;
    if (if_ready !== 1'b1 || mem_ready !== 1'b0 || if_stall !== 1'b0) begin
      failures++; $display("FAIL fetch_done got=if%b mem%b stall%b exp=if1 mem0 stall0", if_ready, mem_ready, if_stall);
    end
    checks++;
    if (if_rdata !== 32'hC0DE0004) begin failures++; $display("FAIL fetch_rdata got=%h exp=c0de0004", if_rdata); end
    checks++;
    if (sram_en !== 1'b0) begin failures++; $display("FAIL fetch_done_en got=%b exp=0", sram_en); end
    if_req = 1'b0;
    step;
    checks++;
    if (if_ready !== 1'b0 || sram_en !== 1'b0) begin
      failures++; $display("FAIL fetch_idle got=rdy%b en%b exp=0 0", if_ready, sram_en);
    end
  endtask

  task automatic test_collision;
    int mem_cyc, if_cyc, mem_cnt, if_cnt;
    mem_cyc = -1; if_cyc = -1; mem_cnt = 0; if_cnt = 0;
    if_addr = 32'h30; mem_addr = 32'h20; if_req = 1'b1; mem_r_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step;
      if (mem_ready) begin
        mem_cnt++; mem_cyc = k;
        checks++;
        if (mem_rdata !== 32'hC0DE0008) begin failures++; $display("FAIL coll_mem_rdata got=%h exp=c0de0008", mem_rdata); end
        mem_r_en = 1'b0;
      end
      if (if_ready) begin
        if_cnt++; if_cyc = k;
        checks++;
        if (if_rdata !== 32'hC0DE000C) begin failures++; $display("FAIL coll_if_rdata got=%h exp=c0de000c", if_rdata); end
        if_req = 1'b0;
      end
      if (k == 2) begin
        checks++;
        if (sram_addr !== 16'h0008) begin failures++; $display("FAIL coll_first_addr got=%h exp=0008", sram_addr); end
      end
      if (k == 7) begin
        checks++;
        if (sram_addr !== 16'h000C) begin failures++; $display("FAIL coll_second_addr got=%h exp=000c", sram_addr); end
      end
      if (k < 9 && if_stall !== 1'b1) begin
        checks++; failures++; $display("FAIL coll_if_stall cyc=%0d got=0 exp=1", k);
      end
    end
    checks++;
    if (mem_cyc != 4 || mem_cnt != 1) begin
      failures++; $display("FAIL coll_mem_timing got=cyc%0d n%0d exp=cyc4 n1", mem_cyc, mem_cnt);
    end
    checks++;
    if (if_cyc != 9 || if_cnt != 1) begin
      failures++; $display("FAIL coll_if_timing got=cyc%0d n%0d exp=cyc9 n1", if_cyc, if_cnt);
    end
  endtask

  task automatic test_store;
    int cnt;
    cnt = 0;
    mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF; mem_w_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step;
      checks++;
      if ({sram_en, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 16'h0100, 32'hDEADBEEF}) begin
        failures++; $display("FAIL store_access cyc=%0d got=%b%b_%h_%h exp=11_0100_deadbeef", k, sram_en, sram_we, sram_addr, sram_wdata);
      end
      checks++;
      if (mem_stall !== 1'b1) begin failures++; $display("FAIL store_stall cyc=%0d got=0 exp=1", k); end
      // Request fields changing mid-access must not disturb the latched values.
      mem_addr = 32'h800; mem_wdata = 32'h0;
    end
    for (int k = 4; k <= 6; k++) begin
      step;
      if (mem_ready) begin
        cnt++;
        checks++;
        if (k != 4) begin failures++; $display("FAIL store_ready_cycle got=%0d exp=4", k); end
        mem_w_en = 1'b0;
      end
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL store_we_off cyc=%0d got=1 exp=0", k); end
    end
    checks++;
    if (cnt != 1) begin failures++; $display("FAIL store_pulses got=%0d exp=1", cnt); end
  endtask

  task automatic test_rw_both;
    mem_addr = 32'h8; mem_wdata = 32'h12345678; mem_r_en = 1'b1; mem_w_en = 1'b1;
    step;
    checks++;
    if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b1, 16'h0002}) begin
      failures++; $display("FAIL rw_both_we got=%b%b_%h exp=11_0002", sram_en, sram_we, sram_addr);
    end
    step; step; step;
    checks++;
    if (mem_ready !== 1'b1) begin failures++; $display("FAIL rw_both_ready got=%b exp=1", mem_ready); end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_access;
    if_addr = 32'h40; if_req = 1'b1;
    step; step;
    checks++;
    if (sram_en !== 1'b1) begin failures++; $display("FAIL rma_pre got=%b exp=1", sram_en); end
    rst = 1'b0;
    #1;
    checks++;
    if ({sram_en, sram_we, if_ready, mem_ready} !== 4'b0000 || if_rdata !== 32'h0) begin
      failures++; $display("FAIL rma_abort got=%b rdata=%h exp=0000 0", {sram_en, sram_we, if_ready, mem_ready}, if_rdata);
    end
    if_req = 1'b0;
    step; step;
    rst = 1'b1;
    step;
    checks++;
    if (sram_en !== 1'b0 || if_ready !== 1'b0) begin
      failures++; $display("FAIL rma_after got=en%b rdy%b exp=0 0", sram_en, if_ready);
    end
    if_req = 1'b1;
    step;
    checks++;
    if (sram_en !== 1'b1 || sram_addr !== 16'h0010) begin
      failures++; $display("FAIL rma_reissue got=en%b addr%h exp=1 0010", sram_en, sram_addr);
    end
    step; step; step;
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'hC0DE0010) begin
      failures++; $display("FAIL rma_reissue_done got=rdy%b %h exp=1 c0de0010", if_ready, if_rdata);
    end
    if_req = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1; second = -1;
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step;
      if (if_ready) begin
        if (first < 0) begin
          first = k; if_addr = 32'h104;
        end else begin
          second = k; if_req = 1'b0;
          checks++;
          if (if_rdata !== 32'hC0DE0041) begin failures++; $display("FAIL b2b_rdata got=%h exp=c0de0041", if_rdata); end
        end
      end
      if (k == 5) begin
        checks++;
        if (sram_en !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", sram_en); end
      end
    end
    checks++;
    if (first != 4 || second != 9) begin
      failures++; $display("FAIL b2b_timing got=%0d,%0d exp=4,9", first, second);
    end
  endtask

  task automatic test_wait1;
    w1_mem_addr = 32'h14; w1_mem_r_en = 1'b1;
    step;
    checks++;
    if (w1_sram_en !== 1'b1 || w1_sram_addr !== 16'h0005 || w1_mem_ready !== 1'b0) begin
      failures++; $display("FAIL w1_access got=en%b addr%h rdy%b exp=1 0005 0", w1_sram_en, w1_sram_addr, w1_mem_ready);
    end
    step;
    checks++;
    if (w1_mem_ready !== 1'b1 || w1_mem_rdata !== 32'hC0DE0005) begin
      failures++; $display("FAIL w1_done got=rdy%b %h exp=1 c0de0005", w1_mem_ready, w1_mem_rdata);
    end
    w1_mem_r_en = 1'b0;
    step;
    checks++;
    if (w1_mem_ready !== 1'b0 || w1_sram_en !== 1'b0) begin
      failures++; $display("FAIL w1_idle got=rdy%b en%b exp=0 0", w1_mem_ready, w1_sram_en);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_fetch;
    test_collision;
    step;
    test_store;
    test_rw_both;
    test_reset_mid_access;
    test_back_to_back;
    step;
    test_wait1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
